// File: rtl/pc_unit.sv
// Program-counter unit for the pipelined MIPS fetch stage: holds the fetch address,
// handles redirects/stalls, continuous or single-step execution, halt, and an update counter.
module pc_unit #(
   parameter int PC_BITS      = 11,
   parameter int INC          = 1,
   parameter int RESET_VECTOR = 0,
   parameter int CNT_BITS     = 16
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_mode,
   input  logic                i_step,
   input  logic                i_stall,
   input  logic                i_jump,
   input  logic [PC_BITS-1:0]  i_jump_addr,
   input  logic                i_branch,
   input  logic [PC_BITS-1:0]  i_branch_addr,
   input  logic                i_halt,
   output logic [PC_BITS-1:0]  o_pc,
   output logic [PC_BITS-1:0]  o_pc_inc,
   output logic                o_active,
   output logic                o_halted,
   output logic [CNT_BITS-1:0] o_upd_count
);

   typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

   localparam logic [PC_BITS-1:0]  INC_W    = PC_BITS'(INC);
   localparam logic [PC_BITS-1:0]  RESET_PC = PC_BITS'(RESET_VECTOR);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

   state_t               state;
   state_t               next_state;
   logic [PC_BITS-1:0]   pc;
   logic [PC_BITS-1:0]   next_pc;
   logic [CNT_BITS-1:0]  count;
   logic                 update;

   always_ff @(negedge i_clock) begin
      if (!i_reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Redirects are checked before the stall because they flush the stalled instruction.
   always_comb begin
      next_state = state;
      next_pc    = pc;
      update     = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               next_state = i_mode ? STEP : RUN;
            end
         end
         RUN, STEP: begin
            if (state == RUN || i_step) begin
               if (i_halt) begin
                  next_state = HALTED;
               end else if (i_jump) begin
                  next_pc = i_jump_addr;
                  update  = 1'b1;
               end else if (i_branch) begin
                  next_pc = i_branch_addr;
                  update  = 1'b1;
               end else if (!i_stall) begin
                  next_pc = pc + INC_W;
                  update  = 1'b1;
               end
            end
         end
         default: begin
            next_state = state;
         end
      endcase
   end

   always_comb begin
      o_active = (state == RUN) || (state == STEP);
      o_halted = (state == HALTED);
   end

   // The update counter saturates so the debug unit never sees a wrapped value.
   always_ff @(negedge i_clock) begin
      if (!i_reset) begin
         pc    <= RESET_PC;
         count <= '0;
      end else begin
         pc <= next_pc;
         if (update && count != CNT_MAX) begin
            count <= count + CNT_ONE;
         end
      end
   end

   assign o_pc        = pc;
   assign o_pc_inc    = pc + INC_W;
   assign o_upd_count = count;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit; a second instance with a 3-bit counter
// shares the stimulus to exercise counter saturation.
module tb_pc_unit;

   typedef struct {
      logic        rst_n;
      logic        start;
      logic        mode;
      logic        step;
      logic        stall;
      logic        jump;
      logic [10:0] ja;
      logic        branch;
      logic [10:0] ba;
      logic        halt;
   } stim_t;

   typedef struct {
      logic [10:0] pc;
      logic [10:0] pc_inc;
      logic        active;
      logic        halted;
      logic [15:0] cnt;
      logic [2:0]  sat;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        start, mode, step, stall, jump, branch, halt;
   logic [10:0] jump_addr, branch_addr;
   logic [10:0] pc, pc_inc, pc_s, pc_inc_s;
   logic        active, halted, active_s, halted_s;
   logic [15:0] upd_count;
   logic [2:0]  upd_count_s;

   stim_t       s;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   int          m_state;
   logic [10:0] m_pc;
   int          m_cnt;
   int          m_sat;

   pc_unit dut (
      .i_clock(clock), .i_reset(reset_n), .i_start(start), .i_mode(mode),
      .i_step(step), .i_stall(stall), .i_jump(jump), .i_jump_addr(jump_addr),
      .i_branch(branch), .i_branch_addr(branch_addr), .i_halt(halt),
      .o_pc(pc), .o_pc_inc(pc_inc), .o_active(active), .o_halted(halted),
      .o_upd_count(upd_count)
   );

   pc_unit #(.CNT_BITS(3)) dut_sat (
      .i_clock(clock), .i_reset(reset_n), .i_start(start), .i_mode(mode),
      .i_step(step), .i_stall(stall), .i_jump(jump), .i_jump_addr(jump_addr),
      .i_branch(branch), .i_branch_addr(branch_addr), .i_halt(halt),
      .o_pc(pc_s), .o_pc_inc(pc_inc_s), .o_active(active_s), .o_halted(halted_s),
      .o_upd_count(upd_count_s)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clearStim();
      s = '{rst_n: 1'b1, start: 1'b0, mode: 1'b0, step: 1'b0, stall: 1'b0,
            jump: 1'b0, ja: 11'h0, branch: 1'b0, ba: 11'h0, halt: 1'b0};
   endtask

   task automatic bump();
      if (m_cnt < 65535) m_cnt++;
      if (m_sat < 7) m_sat++;
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         cmp("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         cmp("pc", 32'(pc), 32'(e.pc));
         cmp("pc_inc", 32'(pc_inc), 32'(e.pc_inc));
         cmp("active", 32'(active), 32'(e.active));
         cmp("halted", 32'(halted), 32'(e.halted));
         cmp("upd_count", 32'(upd_count), 32'(e.cnt));
         cmp("upd_count_sat", 32'(upd_count_s), 32'(e.sat));
         cmp("pc_sat_inst", 32'(pc_s), 32'(e.pc));
      end
   endtask

   // Drives one edge worth of inputs, advances the reference model, then checks after the edge.
   task automatic applyStimulus();
      exp_t e;
      reset_n = s.rst_n; start = s.start; mode = s.mode; step = s.step;
      stall = s.stall; jump = s.jump; jump_addr = s.ja; branch = s.branch;
      branch_addr = s.ba; halt = s.halt;
      if (!s.rst_n) begin
         m_state = 0; m_pc = 11'h0; m_cnt = 0; m_sat = 0;
      end else if (m_state == 0) begin
         if (s.start) m_state = s.mode ? 2 : 1;
      end else if (m_state == 1 || (m_state == 2 && s.step)) begin
         if (s.halt) m_state = 3;
         else if (s.jump) begin m_pc = s.ja; bump(); end
         else if (s.branch) begin m_pc = s.ba; bump(); end
         else if (!s.stall) begin m_pc = m_pc + 11'd1; bump(); end
      end
      e.pc     = m_pc;
      e.pc_inc = m_pc + 11'd1;
      e.active = (m_state == 1 || m_state == 2);
      e.halted = (m_state == 3);
      e.cnt    = 16'(m_cnt);
      e.sat    = 3'(m_sat);
      sb.push_back(e);
      @(posedge clock);
      checkOutput();
      clearStim();
   endtask

   initial begin
      clearStim();
      s.rst_n = 1'b0;
      m_state = 0; m_pc = 11'h0; m_cnt = 0; m_sat = 0;
      reset_n = 1'b0; start = 0; mode = 0; step = 0; stall = 0; jump = 0;
      branch = 0; halt = 0; jump_addr = 0; branch_addr = 0;
      @(posedge clock);
      s.rst_n = 1'b0; applyStimulus();
      s.rst_n = 1'b0; applyStimulus();
      cmp("reset_pc", 32'(pc), 32'h0);
      cmp("reset_active", 32'(active), 32'h0);

      $display("[TB] IDLE ignores redirects, then continuous run");
      s.jump = 1'b1; s.ja = 11'h123; applyStimulus();
      s.start = 1'b1; applyStimulus();
      for (int i = 0; i < 5; i++) applyStimulus();
      cmp("run5_pc", 32'(pc), 32'h5);
      cmp("run5_count", 32'(upd_count), 32'h5);
      cmp("run5_active", 32'(active), 32'h1);

      $display("[TB] stall then branch overriding stall");
      applyStimulus(); applyStimulus();
      for (int i = 0; i < 3; i++) begin s.stall = 1'b1; applyStimulus(); end
      cmp("stall_pc", 32'(pc), 32'h7);
      s.stall = 1'b1; s.branch = 1'b1; s.ba = 11'h040; applyStimulus();
      cmp("branch_over_stall", 32'(pc), 32'h40);

      $display("[TB] jump priority and wrap");
      s.jump = 1'b1; s.ja = 11'h100; s.branch = 1'b1; s.ba = 11'h200; applyStimulus();
      cmp("jump_priority", 32'(pc), 32'h100);
      s.jump = 1'b1; s.ja = 11'h7FF; applyStimulus();
      applyStimulus();
      cmp("wrap_pc", 32'(pc), 32'h0);
      cmp("wrap_pc_inc", 32'(pc_inc), 32'h1);
      cmp("sat_count", 32'(upd_count_s), 32'h7);

      $display("[TB] halt with jump, then ignored inputs");
      s.halt = 1'b1; s.jump = 1'b1; s.ja = 11'h055; applyStimulus();
      cmp("halt_flag", 32'(halted), 32'h1);
      s.jump = 1'b1; s.ja = 11'h066; applyStimulus();
      s.step = 1'b1; applyStimulus();
      s.start = 1'b1; s.mode = 1'b1; applyStimulus();
      cmp("halt_frozen_pc", 32'(pc), 32'h0);
      s.rst_n = 1'b0; applyStimulus();
      cmp("halt_reset_flag", 32'(halted), 32'h0);

      $display("[TB] single-step mode");
      s.start = 1'b1; s.mode = 1'b1; applyStimulus();
      for (int i = 1; i <= 10; i++) begin
         s.step = (i == 3 || i == 7);
         s.jump = (i == 5); s.ja = 11'h3AA;
         applyStimulus();
      end
      cmp("step_pc", 32'(pc), 32'h2);
      cmp("step_count", 32'(upd_count), 32'h2);

      $display("[TB] reset during jump edge");
      s.rst_n = 1'b0; applyStimulus();
      s.start = 1'b1; applyStimulus();
      for (int i = 0; i < 10; i++) applyStimulus();
      cmp("sat_hold", 32'(upd_count_s), 32'h7);
      s.rst_n = 1'b0; s.jump = 1'b1; s.ja = 11'h2AB; applyStimulus();
      cmp("reset_jump_pc", 32'(pc), 32'h0);
      cmp("reset_jump_count", 32'(upd_count), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
